flag_write_arbiter: RTL and testbench

- Shares the single write port of the 3-bit flags register {carry, lessthan, zero} between two requesters: the ALU and the compare unit.
- Provides a context save/restore stack so the control unit can push the current flags on interrupt entry and restore them on return.
- Sits between the requesters and the flags register; its `flag_sel`/`flag_val` outputs drive that register's select/value inputs directly.

---
 rtl/flag_write_arbiter_if.sv | 34 +++
 rtl/flag_write_arbiter.sv | 114 +++++++++++
 tb/tb_flag_write_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flag_write_arbiter_if.sv
// rtl/flag_write_arbiter_if.sv - requester, context-stack and flags-register signals of flag_write_arbiter
interface flag_arb_if #(
   parameter int DEPTH = 4
) ();
   localparam int DW = $clog2(DEPTH + 1);

   logic          alu_req;
   logic [2:0]    alu_sel;
   logic [2:0]    alu_val;
   logic          alu_gnt;
   logic          cmp_req;
   logic [2:0]    cmp_sel;
   logic [2:0]    cmp_val;
   logic          cmp_gnt;
   logic          ctx_push;
   logic          ctx_pop;
   logic [2:0]    flag_in;
   logic [2:0]    flag_sel;
   logic [2:0]    flag_val;
   logic [DW-1:0] stack_depth;
   logic          stack_err;

   modport master (
      output alu_req, alu_sel, alu_val, cmp_req, cmp_sel, cmp_val,
             ctx_push, ctx_pop, flag_in,
      input  alu_gnt, cmp_gnt, flag_sel, flag_val, stack_depth, stack_err
   );

   modport slave (
      input  alu_req, alu_sel, alu_val, cmp_req, cmp_sel, cmp_val,
             ctx_push, ctx_pop, flag_in,
      output alu_gnt, cmp_gnt, flag_sel, flag_val, stack_depth, stack_err
   );
endinterface

// File: rtl/flag_write_arbiter.sv
// rtl/flag_write_arbiter.sv - flags write-port arbiter (ALU/compare) with context save/restore stack
// Optional FLAG_MERGE_EN: grant both requesters together when their write masks are disjoint.
module flag_write_arbiter #(
   parameter int DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   flag_arb_if.slave bus
);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          alu_gnt_q, alu_gnt_d;
   logic          cmp_gnt_q, cmp_gnt_d;
   logic [2:0]    flag_sel_q, flag_sel_d;
   logic [2:0]    flag_val_q, flag_val_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d;
   // rr_q set: the ALU was granted most recently, so the compare unit wins a tie
   logic          rr_q, rr_d;
   logic [2:0]    mem_q [DEPTH];
   logic [2:0]    mem_d [DEPTH];

   logic          full, empty, pop_take;
   logic          alu_elig, cmp_elig, merge;
   logic [IW-1:0] wr_idx, top_idx;

   always_comb begin
      full     = (depth_q == DW'(DEPTH));
      empty    = (depth_q == '0);
      wr_idx   = IW'(depth_q);
      top_idx  = IW'(depth_q - DW'(1));
      pop_take = bus.ctx_pop && !bus.ctx_push && !empty;
      alu_elig = bus.alu_req && !alu_gnt_q;
      cmp_elig = bus.cmp_req && !cmp_gnt_q;
`ifdef FLAG_MERGE_EN
      merge    = alu_elig && cmp_elig && ((bus.alu_sel & bus.cmp_sel) == 3'b000);
`else
      merge    = 1'b0;
`endif

      alu_gnt_d  = 1'b0;
      cmp_gnt_d  = 1'b0;
      flag_sel_d = 3'b000;
      flag_val_d = 3'b000;
      depth_d    = depth_q;
      err_d      = err_q;
      rr_d       = rr_q;
      mem_d      = mem_q;

      if (bus.ctx_push && bus.ctx_pop) begin
         err_d = 1'b1;
      end else if (bus.ctx_push) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            mem_d[wr_idx] = bus.flag_in;
            depth_d       = depth_q + DW'(1);
         end
      end else if (bus.ctx_pop) begin
         if (empty) err_d = 1'b1;
         else       depth_d = depth_q - DW'(1);
      end

      if (pop_take) begin
         flag_sel_d = 3'b111;
         flag_val_d = mem_q[top_idx];
      end else if (merge) begin
         alu_gnt_d  = 1'b1;
         cmp_gnt_d  = 1'b1;
         flag_sel_d = bus.alu_sel | bus.cmp_sel;
         flag_val_d = (bus.alu_val & bus.alu_sel) | (bus.cmp_val & bus.cmp_sel);
      end else if (alu_elig && (!cmp_elig || !rr_q)) begin
         alu_gnt_d  = 1'b1;
         flag_sel_d = bus.alu_sel;
         flag_val_d = bus.alu_val & bus.alu_sel;
         rr_d       = 1'b1;
      end else if (cmp_elig) begin
         cmp_gnt_d  = 1'b1;
         flag_sel_d = bus.cmp_sel;
         flag_val_d = bus.cmp_val & bus.cmp_sel;
         rr_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_gnt_q  <= 1'b0;
         cmp_gnt_q  <= 1'b0;
         flag_sel_q <= 3'b000;
         flag_val_q <= 3'b000;
         depth_q    <= '0;
         err_q      <= 1'b0;
         rr_q       <= 1'b0;
         mem_q      <= '{default: 3'b000};
      end else begin
         alu_gnt_q  <= alu_gnt_d;
         cmp_gnt_q  <= cmp_gnt_d;
         flag_sel_q <= flag_sel_d;
         flag_val_q <= flag_val_d;
         depth_q    <= depth_d;
         err_q      <= err_d;
         rr_q       <= rr_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.alu_gnt     = alu_gnt_q;
   assign bus.cmp_gnt     = cmp_gnt_q;
   assign bus.flag_sel    = flag_sel_q;
   assign bus.flag_val    = flag_val_q;
   assign bus.stack_depth = depth_q;
   assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_flag_write_arbiter.sv
// tb/tb_flag_write_arbiter.sv - directed self-checking bench for flag_write_arbiter
module tb_flag_write_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   flag_arb_if #(.DEPTH(4)) bus ();

   flag_write_arbiter #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle();
      bus.alu_req  = 1'b0;
      bus.alu_sel  = 3'b000;
      bus.alu_val  = 3'b000;
      bus.cmp_req  = 1'b0;
      bus.cmp_sel  = 3'b000;
      bus.cmp_val  = 3'b000;
      bus.ctx_push = 1'b0;
      bus.ctx_pop  = 1'b0;
      bus.flag_in  = 3'b000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle();
      rst = 1'b1;
      #12;
      chk("rst_alu_gnt", 8'(bus.alu_gnt), 8'h0);
      chk("rst_cmp_gnt", 8'(bus.cmp_gnt), 8'h0);
      chk("rst_sel", 8'(bus.flag_sel), 8'h0);
      chk("rst_val", 8'(bus.flag_val), 8'h0);
      chk("rst_depth", 8'(bus.stack_depth), 8'h0);
      chk("rst_err", 8'(bus.stack_err), 8'h0);
      tick();
      rst = 1'b0;

      bus.alu_req = 1'b1; bus.alu_sel = 3'b001; bus.alu_val = 3'b001;
      tick();
      chk("g1_alu_gnt", 8'(bus.alu_gnt), 8'h1);
      chk("g1_sel", 8'(bus.flag_sel), 8'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_gnt", 8'(bus.alu_gnt), 8'h0);
      chk("async_sel", 8'(bus.flag_sel), 8'h0);
      chk("async_val", 8'(bus.flag_val), 8'h0);
      chk("async_depth", 8'(bus.stack_depth), 8'h0);
      chk("async_err", 8'(bus.stack_err), 8'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("rereq_gnt", 8'(bus.alu_gnt), 8'h1);
      chk("rereq_cmp_gnt", 8'(bus.cmp_gnt), 8'h0);
      chk("rereq_sel", 8'(bus.flag_sel), 8'h1);
      chk("rereq_val", 8'(bus.flag_val), 8'h1);
      bus.alu_req = 1'b0;
      tick();
      chk("drop_gnt", 8'(bus.alu_gnt), 8'h0);
      chk("drop_sel", 8'(bus.flag_sel), 8'h0);

      bus.alu_req = 1'b1; bus.alu_sel = 3'b000; bus.alu_val = 3'b111;
      tick();
      chk("sel0_gnt", 8'(bus.alu_gnt), 8'h1);
      chk("sel0_sel", 8'(bus.flag_sel), 8'h0);
      chk("sel0_val", 8'(bus.flag_val), 8'h0);
      tick();
      chk("hold_gap_gnt", 8'(bus.alu_gnt), 8'h0);
      tick();
      chk("hold_regnt", 8'(bus.alu_gnt), 8'h1);
      idle();
      tick();

      do_reset();
      bus.alu_req = 1'b1; bus.alu_sel = 3'b100; bus.alu_val = 3'b111;
      bus.cmp_req = 1'b1; bus.cmp_sel = 3'b010; bus.cmp_val = 3'b010;
`ifdef FLAG_MERGE_EN
      tick();
      chk("m1_alu", 8'(bus.alu_gnt), 8'h1);
      chk("m1_cmp", 8'(bus.cmp_gnt), 8'h1);
      chk("m1_sel", 8'(bus.flag_sel), 8'h6);
      chk("m1_val", 8'(bus.flag_val), 8'h6);
      tick();
      chk("m2_alu", 8'(bus.alu_gnt), 8'h0);
      chk("m2_cmp", 8'(bus.cmp_gnt), 8'h0);
      chk("m2_sel", 8'(bus.flag_sel), 8'h0);
      tick();
      chk("m3_alu", 8'(bus.alu_gnt), 8'h1);
      chk("m3_cmp", 8'(bus.cmp_gnt), 8'h1);
      tick();
`else
      tick();
      chk("c1_alu", 8'(bus.alu_gnt), 8'h1);
      chk("c1_cmp", 8'(bus.cmp_gnt), 8'h0);
      chk("c1_sel", 8'(bus.flag_sel), 8'h4);
      chk("c1_val", 8'(bus.flag_val), 8'h4);
      tick();
      chk("c2_alu", 8'(bus.alu_gnt), 8'h0);
      chk("c2_cmp", 8'(bus.cmp_gnt), 8'h1);
      chk("c2_sel", 8'(bus.flag_sel), 8'h2);
      chk("c2_val", 8'(bus.flag_val), 8'h2);
      tick();
      chk("c3_alu", 8'(bus.alu_gnt), 8'h1);
      chk("c3_sel", 8'(bus.flag_sel), 8'h4);
      tick();
      chk("c4_cmp", 8'(bus.cmp_gnt), 8'h1);
      chk("c4_alu", 8'(bus.alu_gnt), 8'h0);
`endif
      idle();
      tick();

      bus.flag_in = 3'b101; bus.ctx_push = 1'b1;
      tick();
      chk("sr_push_depth", 8'(bus.stack_depth), 8'h1);
      chk("sr_push_sel", 8'(bus.flag_sel), 8'h0);
      bus.ctx_push = 1'b0;
      bus.alu_req = 1'b1; bus.alu_sel = 3'b111; bus.alu_val = 3'b000;
      tick();
      chk("sr_alu_gnt", 8'(bus.alu_gnt), 8'h1);
      chk("sr_alu_sel", 8'(bus.flag_sel), 8'h7);
      chk("sr_alu_val", 8'(bus.flag_val), 8'h0);
      bus.alu_req = 1'b0; bus.flag_in = 3'b000;
      tick();
      bus.ctx_pop = 1'b1;
      tick();
      chk("sr_pop_sel", 8'(bus.flag_sel), 8'h7);
      chk("sr_pop_val", 8'(bus.flag_val), 8'h5);
      chk("sr_pop_depth", 8'(bus.stack_depth), 8'h0);
      chk("sr_pop_gnt", 8'(bus.alu_gnt), 8'h0);
      bus.ctx_pop = 1'b0;

      bus.flag_in = 3'b011; bus.ctx_push = 1'b1;
      tick();
      bus.ctx_push = 1'b0;
      bus.ctx_pop = 1'b1;
      bus.cmp_req = 1'b1; bus.cmp_sel = 3'b001; bus.cmp_val = 3'b001;
      tick();
      chk("pp_pop_sel", 8'(bus.flag_sel), 8'h7);
      chk("pp_pop_val", 8'(bus.flag_val), 8'h3);
      chk("pp_cmp_gnt0", 8'(bus.cmp_gnt), 8'h0);
      chk("pp_depth", 8'(bus.stack_depth), 8'h0);
      bus.ctx_pop = 1'b0;
      tick();
      chk("pp_cmp_gnt1", 8'(bus.cmp_gnt), 8'h1);
      chk("pp_cmp_sel", 8'(bus.flag_sel), 8'h1);
      chk("pp_cmp_val", 8'(bus.flag_val), 8'h1);
      chk("pp_err", 8'(bus.stack_err), 8'h0);
      idle();
      tick();

      for (int i = 0; i < 4; i++) begin
         bus.flag_in = 3'(i + 1);
         bus.ctx_push = 1'b1;
         tick();
      end
      chk("full_depth", 8'(bus.stack_depth), 8'h4);
      chk("full_err0", 8'(bus.stack_err), 8'h0);
      bus.flag_in = 3'b111;
      tick();
      chk("ovf_depth", 8'(bus.stack_depth), 8'h4);
      chk("ovf_err", 8'(bus.stack_err), 8'h1);
      bus.ctx_push = 1'b0;
      bus.ctx_pop = 1'b1;
      tick();
      chk("lifo_val", 8'(bus.flag_val), 8'h4);
      chk("lifo_depth", 8'(bus.stack_depth), 8'h3);
      idle();

      do_reset();
      chk("rst2_err", 8'(bus.stack_err), 8'h0);
      bus.ctx_pop = 1'b1;
      tick();
      chk("unf_err", 8'(bus.stack_err), 8'h1);
      chk("unf_sel", 8'(bus.flag_sel), 8'h0);
      chk("unf_depth", 8'(bus.stack_depth), 8'h0);
      idle();

      do_reset();
      bus.flag_in = 3'b010; bus.ctx_push = 1'b1;
      tick();
      bus.ctx_pop = 1'b1;
      tick();
      chk("pp_both_depth", 8'(bus.stack_depth), 8'h1);
      chk("pp_both_err", 8'(bus.stack_err), 8'h1);
      chk("pp_both_sel", 8'(bus.flag_sel), 8'h0);
      idle();
      tick();
      chk("err_sticky", 8'(bus.stack_err), 8'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
